// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage.
//   stl_e        : staller command encoding (GO/STALL/BUBBLE, 11 reserved)
//   cmd_e        : decoded command after folding the reserved code into STALL
//   stl_decode() : maps a raw 2-bit staller command onto cmd_e
package pipe_stage_elastic_pkg;

  typedef enum logic [1:0] {
    STL_GO     = 2'b00,
    STL_STALL  = 2'b01,
    STL_BUBBLE = 2'b10,
    STL_RSVD   = 2'b11
  } stl_e;

  typedef enum logic [1:0] {
    CMD_GO,
    CMD_STALL,
    CMD_BUBBLE
  } cmd_e;

  localparam int unsigned OCC_W = 2;

  // The reserved code behaves exactly like STALL.
  function automatic cmd_e stl_decode(input logic [1:0] stl);
    case (stl)
      STL_GO:     return CMD_GO;
      STL_BUBBLE: return CMD_BUBBLE;
      default:    return CMD_STALL;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_elastic_if.sv
// Valid/ready payload channel used on both sides of the elastic stage.
//   valid : sender has a payload
//   data  : payload, DATA_W bits
//   ready : receiver accepts this cycle
// master = sending side, slave = receiving side.
interface pipe_stage_elastic_if #(
  parameter int unsigned DATA_W = 72
) ();

  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/pipe_stage_elastic_bubcnt.sv
// Saturating event counter used for the bubble statistics.
//   clk_i : clock
//   rst_i : synchronous active-high reset, clears the count
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at all-ones
module pipe_stage_elastic_bubcnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register between EX/MEM/WB.
// Carries an opaque payload, obeys the staller's Go/Stall/Bubble command and
// adds a valid/ready handshake with an optional two-entry skid buffer.
//   dclk      : clock, rising edge
//   rst       : synchronous active-high reset
//   stl_i     : staller command (GO / STALL / BUBBLE, 11 = STALL)
//   up_if     : producer channel (valid_i, data_i in; ready_o out)
//   dn_if     : consumer channel (valid_o, data_o out; ready_i in)
//   occ_o     : entries held (0..2)
//   bub_cnt_o : saturating count of BUBBLE cycles since reset
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int unsigned       DATA_W    = 72,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter bit                SKID      = 1'b1,
  parameter int unsigned       CNT_W     = 16
) (
  input  logic                 dclk,
  input  logic                 rst,
  input  logic [1:0]           stl_i,
  pipe_stage_elastic_if.slave  up_if,
  pipe_stage_elastic_if.master dn_if,
  output logic [OCC_W-1:0]     occ_o,
  output logic [CNT_W-1:0]     bub_cnt_o
);

  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_i;
  logic              ready_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;

  assign valid_i     = up_if.valid;
  assign data_i      = up_if.data;
  assign ready_i     = dn_if.ready;
  assign up_if.ready = ready_o;
  assign dn_if.valid = valid_o;
  assign dn_if.data  = data_o;

  cmd_e cmd;
  logic cmd_go;
  logic cmd_bubble;

  assign cmd        = stl_decode(stl_i);
  assign cmd_go     = (cmd == CMD_GO);
  assign cmd_bubble = (cmd == CMD_BUBBLE);

  logic              main_v_q, main_v_d;
  logic [DATA_W-1:0] main_d_q, main_d_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] skid_d_q, skid_d_d;

  logic push;
  logic pop;

  // With the skid buffer, ready depends only on registered state; the
  // staller gate is the only combinational term.
  always_comb begin
    if (SKID) begin
      ready_o = cmd_go && !skid_v_q;
    end else begin
      ready_o = cmd_go && (!main_v_q || ready_i);
    end
  end

  assign valid_o = cmd_go && main_v_q;
  assign data_o  = main_v_q ? main_d_q : NOP_VALUE;
  assign push    = valid_i && ready_o;
  assign pop     = valid_o && ready_i;
  assign occ_o   = {1'b0, main_v_q} + {1'b0, skid_v_q};

  always_comb begin
    main_v_d = main_v_q;
    main_d_d = main_d_q;
    skid_v_d = skid_v_q;
    skid_d_d = skid_d_q;
    if (cmd_bubble) begin
      main_v_d = 1'b0;
      main_d_d = NOP_VALUE;
      skid_v_d = 1'b0;
    end else if (cmd_go) begin
      if (SKID) begin
        // A full skid implies ready_o=0, so a skid refill never races a push.
        if (pop && skid_v_q) begin
          main_d_d = skid_d_q;
          skid_v_d = 1'b0;
        end else if (push && (!main_v_q || pop)) begin
          main_v_d = 1'b1;
          main_d_d = data_i;
        end else if (push) begin
          skid_v_d = 1'b1;
          skid_d_d = data_i;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end else begin
        if (push) begin
          main_v_d = 1'b1;
          main_d_d = data_i;
        end else if (pop) begin
          main_v_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      main_v_q <= 1'b0;
      main_d_q <= NOP_VALUE;
    end else begin
      main_v_q <= main_v_d;
      main_d_q <= main_d_d;
    end
  end

  if (SKID) begin : g_skid
    always_ff @(posedge dclk) begin
      if (rst) begin
        skid_v_q <= 1'b0;
        skid_d_q <= NOP_VALUE;
      end else begin
        skid_v_q <= skid_v_d;
        skid_d_q <= skid_d_d;
      end
    end
  end else begin : g_no_skid
    assign skid_v_q = 1'b0;
    assign skid_d_q = NOP_VALUE;
  end

  pipe_stage_elastic_bubcnt #(
    .CNT_W(CNT_W)
  ) u_bubcnt (
    .clk_i (dclk),
    .rst_i (rst),
    .inc_i (cmd_bubble),
    .cnt_o (bub_cnt_o)
  );

endmodule
